operand_fetch: RTL
==================

Name: operand_fetch

Overview:
- Reader side of the 16-entry, 16-bit register file: drives both read addresses and owns the ID/EX pipeline register.
- Resolves RAW hazards by forwarding from the EX and MEM stages.
- Stalls decode for one cycle on a load-use hazard and inserts a bubble.
- Handles LLB/LHB by reading the old destination value as operand 1.

Parameters:
DW, 16, data width
AW, 4, register-ID width (2^AW registers; R0 hardwired zero)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  decoded instruction present
id_ready  out  1  instruction accepted this cycle
id_src1  in  AW  source reg 1
id_src2  in  AW  source reg 2
id_dst  in  AW  destination reg
id_we  in  1  instruction writes id_dst
id_load  in  1  instruction is a memory load
id_half  in  2  00 full write, 01 LLB, 10 LHB (11 illegal, treated as 00)
flush  in  1  branch redirect; kill ID/EX contents
rf_src1  out  AW  regfile read address 1
rf_src2  out  AW  regfile read address 2
rf_data1  in  DW  regfile read data 1 (WB write-through already inside regfile)
rf_data2  in  DW  regfile read data 2
ex_result  in  DW  combinational ALU result of instruction in EX
mem_result  in  DW  result of instruction in MEM (load data or ALU)
ex_valid  out  1  ID/EX holds a live instruction
ex_op1  out  DW  operand 1
ex_op2  out  DW  operand 2
ex_dst  out  AW  destination
ex_we  out  1  write enable
ex_load  out  1  load flag
ex_half  out  2  partial-write type

Behaviour:
- Reset (rst_n low at a clk edge):
  - ex_valid, ex_we, ex_load = 0; ex_op1, ex_op2 = 0; ex_dst = 0; ex_half = 00.
  - Internal MEM shadow (mem_valid, mem_dst, mem_we) = 0.
  - Reset has priority over flush and accept.
- Read addressing is combinational:
  - rf_src1 = (id_half != 00) ? id_dst : id_src1.
  - rf_src2 = id_src2.
- Effective source n = rf_srcN. A source "needs" forwarding only if it is nonzero (R0 never forwarded, always reads 0).
- Forwarding priority per operand, youngest first:
  1. EX match (ex_valid & ex_we & ex_dst==src & !ex_load): ex_result.
  2. MEM match (mem_valid & mem_we & mem_dst==src): mem_result.
  3. Otherwise rf_dataN.
  - Source == 0 forces operand to 0 regardless of rf_data.
- Load-use hazard: id_valid & ex_valid & ex_load & ex_we & ex_dst!=0 & ex_dst matches either effective source.
  - The id_src2 match applies only when id_half==00; LLB/LHB use only operand 1.
- id_ready = !hazard | flush. Under flush the decode slot is discarded upstream anyway.
- At each clk edge (not reset):
  - MEM shadow <= {ex_valid, ex_dst, ex_we}. Downstream never stalls.
  - If flush: ex_valid <= 0, ex_we <= 0. The instruction at id is not captured.
  - Else if hazard: bubble; ex_valid <= 0, ex_we <= 0, ex_load <= 0. Upstream holds its instruction.
  - Else if id_valid: capture the forwarded operands and all id_* fields; ex_valid <= 1.
  - Else: ex_valid <= 0, ex_we <= 0.
- Latency: operands visible on ex_* one cycle after acceptance. A load-use costs exactly one bubble; after the bubble the load sits in MEM and mem_result forwards.
- Flush during a hazard cycle: flush wins; the bubble is identical and the stall releases because id_ready=1.
- Partial writes: ex_op1 carries the full old destination value; EX performs the byte merge.
- Writes to R0: ex_we may be 1, but never forwarded since the source-zero check blocks them.

Decomposition:
- Shared package:
  - DW, AW constants.
  - HALF_FULL=2'b00, HALF_LLB=2'b01, HALF_LHB=2'b10.
  - REG_ZERO=0.
- Sub-module fwd_mux: select for one operand (src, ex/mem tags, three data inputs → operand). Instantiated twice.

Test Plan:
- No-hazard baseline:
  - Set rf_data1=16'h1234, rf_data2=16'h00FF.
  - Issue src1=3, src2=4, dst=5, we=1.
  - Next cycle: ex_valid=1, ex_op1=16'h1234, ex_op2=16'h00FF, ex_dst=5, id_ready stayed 1.
- EX and MEM forwarding:
  - Issue ADD r5 (ex_result=16'hAAAA), then ADD r6 (ex_result=16'hBBBB).
  - Then use src1=5, src2=6 while mem_result=16'hAAAA.
  - Expect ex_op1=16'hAAAA from MEM and ex_op2=16'hBBBB from EX.
- Load-use stall:
  - Issue LW r7, then ADD src1=7.
  - Expect id_ready=0 for one cycle and ex_valid=0 next cycle.
  - With mem_result=16'h5A5A, the following cycle accepts with ex_op1=16'h5A5A.
- R0 handling:
  - In-flight write to r0 with ex_result=16'hFFFF; next instruction reads src1=0 with rf_data1=16'hDEAD.
  - Expect ex_op1=0, no stall even if a load targets r0.
- LHB old-value read:
  - id_half=10, dst=9, id_src1=2.
  - Expect rf_src1=9.
  - A prior load to r9 in EX causes a stall even though src2 matches nothing.
- Flush and reset:
  - Assert flush during a load-use stall: ex_valid=0, id_ready=1.
  - Drive rst_n=0 with id_valid=1: after the edge all ex_* = 0 and the MEM shadow cleared, so no spurious forward the next cycle.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand fetch stage: widths, partial-write encodings, R0 id.
package operand_fetch_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    // Partial-write type carried with each instruction
    localparam logic [1:0] HALF_FULL = 2'b00;
    localparam logic [1:0] HALF_LLB  = 2'b01;
    localparam logic [1:0] HALF_LHB  = 2'b10;

    localparam logic [AW-1:0] REG_ZERO = '0;

    // Fold the illegal 2'b11 encoding onto a full write
    function automatic logic [1:0] half_normalize(input logic [1:0] half);
        return (half == 2'b11) ? HALF_FULL : half;
    endfunction

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Per-operand bypass select: R0 forces zero, then EX (youngest), then MEM, then regfile.
module operand_fetch_fwd_mux #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 4
) (
    input  logic [AW-1:0] src_i,
    input  logic          ex_fwd_en_i,
    input  logic [AW-1:0] ex_dst_i,
    input  logic          mem_fwd_en_i,
    input  logic [AW-1:0] mem_dst_i,
    input  logic [DW-1:0] ex_data_i,
    input  logic [DW-1:0] mem_data_i,
    input  logic [DW-1:0] rf_data_i,
    output logic [DW-1:0] operand_o
);

    import operand_fetch_pkg::*;

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = ex_fwd_en_i  && (ex_dst_i  == src_i);
    assign mem_hit = mem_fwd_en_i && (mem_dst_i == src_i);

    // Priority select; R0 check first so writes to R0 never leak through a bypass
    always_comb begin
        operand_o = rf_data_i;
        if (src_i == REG_ZERO) begin
            operand_o = '0;
        end else if (ex_hit) begin
            operand_o = ex_data_i;
        end else if (mem_hit) begin
            operand_o = mem_data_i;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: regfile read addressing, EX/MEM forwarding, load-use stall and the ID/EX register.
module operand_fetch #(
    parameter int unsigned DW = operand_fetch_pkg::DW,
    parameter int unsigned AW = operand_fetch_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [AW-1:0] id_src1,
    input  logic [AW-1:0] id_src2,
    input  logic [AW-1:0] id_dst,
    input  logic          id_we,
    input  logic          id_load,
    input  logic [1:0]    id_half,
    input  logic          flush,
    output logic [AW-1:0] rf_src1,
    output logic [AW-1:0] rf_src2,
    input  logic [DW-1:0] rf_data1,
    input  logic [DW-1:0] rf_data2,
    input  logic [DW-1:0] ex_result,
    input  logic [DW-1:0] mem_result,
    output logic          ex_valid,
    output logic [DW-1:0] ex_op1,
    output logic [DW-1:0] ex_op2,
    output logic [AW-1:0] ex_dst,
    output logic          ex_we,
    output logic          ex_load,
    output logic [1:0]    ex_half
);

    import operand_fetch_pkg::*;

    // ID/EX pipeline register
    logic          ex_valid_q, ex_valid_d;
    logic [DW-1:0] ex_op1_q,   ex_op1_d;
    logic [DW-1:0] ex_op2_q,   ex_op2_d;
    logic [AW-1:0] ex_dst_q,   ex_dst_d;
    logic          ex_we_q,    ex_we_d;
    logic          ex_load_q,  ex_load_d;
    logic [1:0]    ex_half_q,  ex_half_d;

    // Shadow of the instruction now in MEM, only the tags needed for forwarding
    logic          mem_valid_q, mem_valid_d;
    logic [AW-1:0] mem_dst_q,   mem_dst_d;
    logic          mem_we_q,    mem_we_d;

    logic [1:0]    half_eff;
    logic          is_partial;
    logic          ex_fwd_en;
    logic          mem_fwd_en;
    logic          load_pending;
    logic          hit_src1;
    logic          hit_src2;
    logic          hazard;
    logic [DW-1:0] fwd_op1;
    logic [DW-1:0] fwd_op2;

    // Partial writes read the old destination value through port 1
    always_comb begin
        half_eff   = half_normalize(id_half);
        is_partial = (half_eff != HALF_FULL);
        rf_src1    = is_partial ? id_dst : id_src1;
        rf_src2    = id_src2;
    end

    // A load in EX has no result yet, so it is excluded from EX forwarding
    assign ex_fwd_en  = ex_valid_q && ex_we_q && !ex_load_q;
    assign mem_fwd_en = mem_valid_q && mem_we_q;

    // Load-use detection; operand 2 is unused by LLB/LHB so it cannot cause a stall
    always_comb begin
        load_pending = ex_valid_q && ex_load_q && ex_we_q && (ex_dst_q != REG_ZERO);
        hit_src1     = (ex_dst_q == rf_src1);
        hit_src2     = !is_partial && (ex_dst_q == rf_src2);
        hazard       = id_valid && load_pending && (hit_src1 || hit_src2);
        id_ready     = !hazard || flush;
    end

    operand_fetch_fwd_mux #(
        .DW(DW),
        .AW(AW)
    ) u_fwd_mux1 (
        .src_i       (rf_src1),
        .ex_fwd_en_i (ex_fwd_en),
        .ex_dst_i    (ex_dst_q),
        .mem_fwd_en_i(mem_fwd_en),
        .mem_dst_i   (mem_dst_q),
        .ex_data_i   (ex_result),
        .mem_data_i  (mem_result),
        .rf_data_i   (rf_data1),
        .operand_o   (fwd_op1)
    );

    operand_fetch_fwd_mux #(
        .DW(DW),
        .AW(AW)
    ) u_fwd_mux2 (
        .src_i       (rf_src2),
        .ex_fwd_en_i (ex_fwd_en),
        .ex_dst_i    (ex_dst_q),
        .mem_fwd_en_i(mem_fwd_en),
        .mem_dst_i   (mem_dst_q),
        .ex_data_i   (ex_result),
        .mem_data_i  (mem_result),
        .rf_data_i   (rf_data2),
        .operand_o   (fwd_op2)
    );

    // Next-state for ID/EX and the MEM shadow; flush beats bubble beats capture
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_op1_d    = ex_op1_q;
        ex_op2_d    = ex_op2_q;
        ex_dst_d    = ex_dst_q;
        ex_we_d     = ex_we_q;
        ex_load_d   = ex_load_q;
        ex_half_d   = ex_half_q;

        // Downstream never stalls, so EX always advances into MEM
        mem_valid_d = ex_valid_q;
        mem_dst_d   = ex_dst_q;
        mem_we_d    = ex_we_q;

        if (flush) begin
            ex_valid_d = 1'b0;
            ex_we_d    = 1'b0;
        end else if (hazard) begin
            ex_valid_d = 1'b0;
            ex_we_d    = 1'b0;
            ex_load_d  = 1'b0;
        end else if (id_valid) begin
            ex_valid_d = 1'b1;
            ex_op1_d   = fwd_op1;
            ex_op2_d   = fwd_op2;
            ex_dst_d   = id_dst;
            ex_we_d    = id_we;
            ex_load_d  = id_load;
            ex_half_d  = half_eff;
        end else begin
            ex_valid_d = 1'b0;
            ex_we_d    = 1'b0;
        end
    end

    // State update with synchronous active-low reset taking priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_op1_q    <= '0;
            ex_op2_q    <= '0;
            ex_dst_q    <= '0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_half_q   <= HALF_FULL;
            mem_valid_q <= 1'b0;
            mem_dst_q   <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_op1_q    <= ex_op1_d;
            ex_op2_q    <= ex_op2_d;
            ex_dst_q    <= ex_dst_d;
            ex_we_q     <= ex_we_d;
            ex_load_q   <= ex_load_d;
            ex_half_q   <= ex_half_d;
            mem_valid_q <= mem_valid_d;
            mem_dst_q   <= mem_dst_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_op1   = ex_op1_q;
    assign ex_op2   = ex_op2_q;
    assign ex_dst   = ex_dst_q;
    assign ex_we    = ex_we_q;
    assign ex_load  = ex_load_q;
    assign ex_half  = ex_half_q;

endmodule
